drop_controller: RTL and testbench
==================================

# drop_controller

Consumer side of the gravity timer interface: receives the timer's `moveDown` ticks and the debounced player button pulses, arbitrates them into a single registered move-command stream toward the game engine, and drives the timer's `timeVal` reload period and `rstTimer` restart pulse. It sits between the input/timer logic and the board engine. It also turns a hard drop into a burst of DOWN commands ending in LOCK, and scales gravity speed with the number of cleared lines.

## Interface
- `BASE_PERIOD`, 25_000_000: gravity period at level 0, in clk cycles.
- `STEP`, 2_000_000: period reduction per level.
- `MIN_PERIOD`, 5_000_000: floor on the period.
- `LINES_PER_LEVEL`, 10: cleared lines per level increment.
- `TIME_W`, 32: width of `timeVal`.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-high.
- `moveDown` in 1: gravity tick from the timer; rising edge detected internally.
- `btnLeft`, `btnRight`, `btnRotate`, `btnDown`, `btnDrop` in 1 each: single-cycle press pulses, already synchronized and debounced.
- `linesCleared` in 3: number of lines cleared (0-4); qualified by `linesValid`.
- `linesValid` in 1: single-cycle strobe for `linesCleared`.
- `cmdValid` out 1: command available.
- `cmd` out 3: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DOWN, 5 LOCK; 0 when idle.
- `cmdReady` in 1: engine accepts the command this cycle.
- `cmdBlocked` in 1: accepted move collided; sampled only when `cmdValid & cmdReady`.
- `timeVal` out TIME_W: gravity period to the timer.
- `rstTimer` out 1: single-cycle timer restart pulse.
- `level` out 4: current level, 0-15.

## Operation
- Reset values: `cmdValid`=0, `cmd`=0, `rstTimer`=0, `level`=0, `timeVal`=BASE_PERIOD, line total=0, all pending flags clear, state IDLE.
- Pending flags:
  - One flag each for gravity, soft-down, rotate, left and right.
  - A flag sets on its pulse (gravity sets on the `moveDown` rising edge).
  - A flag clears when its command is accepted.
  - If a new pulse arrives in the same cycle as its accept, the set wins.
- States: IDLE, ISSUE, DROP, LOCK.
- IDLE:
  - If `btnDrop` was pulsed, go to DROP and discard all pending flags.
  - Otherwise, if any flag is pending, go to ISSUE. Priority: DOWN (gravity or soft) > ROTATE > LEFT > RIGHT.
  - A single DOWN satisfies both the gravity and soft-down flags; both clear on its accept.
- ISSUE:
  - Hold `cmdValid`=1 with `cmd` stable until `cmdReady`.
  - On accept: a DOWN with `cmdBlocked`=1 goes to LOCK; otherwise go to IDLE.
- DROP:
  - Issue DOWN repeatedly, one per accept.
  - All button pulses and gravity ticks are ignored and discarded.
  - The first accepted DOWN with `cmdBlocked`=1 goes to LOCK.
- LOCK:
  - Issue LOCK until accepted.
  - On accept, clear all pending flags and go to IDLE.
  - `cmdBlocked` is ignored for LOCK.
- `rstTimer` pulses for one cycle after any of these accepts:
  - a DOWN that contained a soft-down;
  - any DOWN issued in DROP;
  - LOCK.
  - A pure gravity DOWN does not pulse `rstTimer`, because the timer self-reloads.
- Level arithmetic:
  - On `linesValid`, add `linesCleared` to an 8-bit line total that saturates at 255.
  - `level` = min(total / LINES_PER_LEVEL, 15).
  - `timeVal` = max(BASE_PERIOD − level·STEP, MIN_PERIOD), computed without underflow.
- Reset mid-command drops `cmdValid` immediately (asynchronous); no partial command survives.

## Timing
- A press pulse at edge N sets the flag at edge N. `cmdValid` rises at edge N+1 when the block was IDLE.
- After an accept, `cmdValid` is low for at least one cycle (return through IDLE). LOCK follows a blocked DOWN on the next cycle.
- `rstTimer` is registered: high for exactly the cycle after the accepting edge.
- `level` updates one cycle after `linesValid`. `timeVal` updates one cycle after `level`.
- `cmd` and `cmdValid` must not change while `cmdValid`=1 and `cmdReady`=0.

## Test plan
- **Reset:** assert `rst` mid-ISSUE → `cmdValid`=0, `timeVal`=25_000_000 and `level`=0 immediately. No command appears after release until a new pulse.
- **Priority/backpressure:** `btnLeft`, `btnRotate` and a `moveDown` edge in the same cycle, with `cmdReady` low for 3 cycles → DOWN held stable; then ROTATE, then LEFT. No `rstTimer` pulse.
- **Soft-down:** `btnDown`, accept with `cmdBlocked`=0 → `rstTimer` one-cycle pulse. Repeat with `cmdBlocked`=1 → LOCK issued next, then a second `rstTimer` pulse.
- **Hard drop:** `btnDrop`, engine blocks on the 4th DOWN, `btnLeft` pulsed during the burst → exactly 4 DOWN then 1 LOCK, 5 `rstTimer` pulses, no LEFT afterwards.
- **Level:** four `linesValid` strobes with `linesCleared`=3 (total 12) → `level`=1, `timeVal`=23_000_000.
  - Drive the total to 255 → `level`=15 and `timeVal`=5_000_000 (floor).
- **Simultaneous set/clear:** `btnRight` pulsed in the cycle a RIGHT is accepted → a second RIGHT is issued.

Source files
------------

// File: rtl/drop_controller.sv
// Move-command arbiter between the input/gravity-timer logic and the board engine.
// Turns gravity ticks and button pulses into one registered command stream and scales gravity speed with level.
module drop_controller #(
    parameter int BASE_PERIOD     = 25_000_000,
    parameter int STEP            = 2_000_000,
    parameter int MIN_PERIOD      = 5_000_000,
    parameter int LINES_PER_LEVEL = 10,
    parameter int TIME_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              moveDown,
    input  logic              btnLeft,
    input  logic              btnRight,
    input  logic              btnRotate,
    input  logic              btnDown,
    input  logic              btnDrop,
    input  logic [2:0]        linesCleared,
    input  logic              linesValid,
    output logic              cmdValid,
    output logic [2:0]        cmd,
    input  logic              cmdReady,
    input  logic              cmdBlocked,
    output logic [TIME_W-1:0] timeVal,
    output logic              rstTimer,
    output logic [3:0]        level
);

    typedef enum logic [1:0] {IDLE, ISSUE, DROP, LOCK} state_t;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DOWN   = 3'd4,
        CMD_LOCK   = 3'd5
    } cmd_t;

    state_t state, state_next;
    cmd_t   issue_q, issue_next;

    logic move_d, move_rise;
    logic grav_p, soft_p, rot_p, left_p, right_p, drop_p;
    logic accept;
    logic clr_all, clr_down, clr_rot, clr_left, clr_right;
    logic timer_pulse;

    logic [7:0]          line_total;
    logic [8:0]          line_sum;
    logic [7:0]          level_raw;
    logic [3:0]          level_next;
    logic [TIME_W+3:0]   period_dec;
    logic [TIME_W-1:0]   period_next;

    assign move_rise = moveDown & ~move_d;
    assign cmdValid  = (state != IDLE);
    assign accept    = cmdValid & cmdReady;

    always_comb begin
        unique case (state)
            ISSUE:   cmd = issue_q;
            DROP:    cmd = CMD_DOWN;
            LOCK:    cmd = CMD_LOCK;
            default: cmd = CMD_NONE;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        issue_next  = issue_q;
        clr_all     = 1'b0;
        clr_down    = 1'b0;
        clr_rot     = 1'b0;
        clr_left    = 1'b0;
        clr_right   = 1'b0;
        timer_pulse = 1'b0;
        unique case (state)
            IDLE: begin
                if (drop_p) begin
                    state_next = DROP;
                    clr_all    = 1'b1;
                end else if (grav_p || soft_p) begin
                    state_next = ISSUE;
                    issue_next = CMD_DOWN;
                end else if (rot_p) begin
                    state_next = ISSUE;
                    issue_next = CMD_ROTATE;
                end else if (left_p) begin
                    state_next = ISSUE;
                    issue_next = CMD_LEFT;
                end else if (right_p) begin
                    state_next = ISSUE;
                    issue_next = CMD_RIGHT;
                end
            end
            ISSUE: begin
                if (accept) begin
                    state_next = IDLE;
                    unique case (issue_q)
                        CMD_DOWN: begin
                            clr_down    = 1'b1;
                            // A pure gravity DOWN leaves the timer free-running.
                            timer_pulse = soft_p;
                            if (cmdBlocked) state_next = LOCK;
                        end
                        CMD_ROTATE: clr_rot   = 1'b1;
                        CMD_LEFT:   clr_left  = 1'b1;
                        CMD_RIGHT:  clr_right = 1'b1;
                        default:    ;
                    endcase
                end
            end
            DROP: begin
                clr_all = 1'b1;
                if (accept) begin
                    timer_pulse = 1'b1;
                    if (cmdBlocked) state_next = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    timer_pulse = 1'b1;
                    clr_all     = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            issue_q  <= CMD_NONE;
            move_d   <= 1'b0;
            rstTimer <= 1'b0;
        end else begin
            state    <= state_next;
            issue_q  <= issue_next;
            move_d   <= moveDown;
            rstTimer <= timer_pulse;
        end
    end

    // A pulse arriving with its own accept keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr_all) begin
            grav_p  <= 1'b0;
            soft_p  <= 1'b0;
            rot_p   <= 1'b0;
            left_p  <= 1'b0;
            right_p <= 1'b0;
            drop_p  <= 1'b0;
        end else begin
            grav_p  <= move_rise | (grav_p & ~clr_down);
            soft_p  <= btnDown   | (soft_p & ~clr_down);
            rot_p   <= btnRotate | (rot_p & ~clr_rot);
            left_p  <= btnLeft   | (left_p & ~clr_left);
            right_p <= btnRight  | (right_p & ~clr_right);
            drop_p  <= btnDrop   | drop_p;
        end
    end

    // Period is compared before subtracting so a large level never underflows.
    always_comb begin
        line_sum   = {1'b0, line_total} + {6'd0, linesCleared};
        level_raw  = line_total / 8'(LINES_PER_LEVEL);
        level_next = (level_raw > 8'd15) ? 4'd15 : level_raw[3:0];
        period_dec = (TIME_W+4)'(level) * (TIME_W+4)'(STEP);
        if (period_dec + (TIME_W+4)'(MIN_PERIOD) >= (TIME_W+4)'(BASE_PERIOD))
            period_next = TIME_W'(MIN_PERIOD);
        else
            period_next = TIME_W'((TIME_W+4)'(BASE_PERIOD) - period_dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_total <= 8'd0;
            level      <= 4'd0;
            timeVal    <= TIME_W'(BASE_PERIOD);
        end else begin
            if (linesValid) line_total <= line_sum[8] ? 8'hFF : line_sum[7:0];
            level   <= level_next;
            timeVal <= period_next;
        end
    end

endmodule

// File: tb/tb_drop_controller.sv
// Directed self-checking bench for drop_controller: priority, backpressure, soft/hard drop, level scaling, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_drop_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        moveDown, btnLeft, btnRight, btnRotate, btnDown, btnDrop;
    logic [2:0]  linesCleared;
    logic        linesValid;
    logic        cmdValid;
    logic [2:0]  cmd;
    logic        cmdReady, cmdBlocked;
    logic [31:0] timeVal;
    logic        rstTimer;
    logic [3:0]  level;

    int vectors     = 0;
    int miscompares = 0;
    int tpulses     = 0;
    int acc_word    = 0;

    drop_controller dut (
        .clk(clk), .rst(rst), .moveDown(moveDown),
        .btnLeft(btnLeft), .btnRight(btnRight), .btnRotate(btnRotate),
        .btnDown(btnDown), .btnDrop(btnDrop),
        .linesCleared(linesCleared), .linesValid(linesValid),
        .cmdValid(cmdValid), .cmd(cmd), .cmdReady(cmdReady), .cmdBlocked(cmdBlocked),
        .timeVal(timeVal), .rstTimer(rstTimer), .level(level)
    );

    always #5 clk = ~clk;

    // Accepted commands packed as octal digits, oldest first.
    always @(posedge clk) if (!rst && cmdValid && cmdReady) acc_word = (acc_word << 3) | int'(cmd);
    always @(negedge clk) if (rstTimer) tpulses++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

    task automatic clear_logs();
        tpulses  = 0;
        acc_word = 0;
    endtask

    task automatic strobe_lines(input logic [2:0] n);
        @(negedge clk); linesValid = 1'b1; linesCleared = n;
        @(negedge clk); linesValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {moveDown, btnLeft, btnRight, btnRotate, btnDown, btnDrop} = '0;
        linesCleared = 3'd0; linesValid = 1'b0; cmdReady = 1'b0; cmdBlocked = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if ({cmdValid, cmd, rstTimer} !== 5'b0) begin miscompares++;
            $display("FAIL reset_cmd: got valid/cmd/rstTimer %b expected 00000", {cmdValid, cmd, rstTimer}); end
        vectors++; if (level !== 4'd0) begin miscompares++;
            $display("FAIL reset_level: got %0d expected 0", level); end
        vectors++; if (timeVal !== 32'd25_000_000) begin miscompares++;
            $display("FAIL reset_timeVal: got %0d expected 25000000", timeVal); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (cmdValid !== 1'b0) begin miscompares++;
            $display("FAIL reset_release_idle: got cmdValid %b expected 0", cmdValid); end
    endtask

    task automatic test_priority();
        clear_logs();
        @(negedge clk); btnLeft = 1'b1; btnRotate = 1'b1; moveDown = 1'b1; cmdReady = 1'b0;
        @(negedge clk); btnLeft = 1'b0; btnRotate = 1'b0; moveDown = 1'b0;
        vectors++; if (cmdValid !== 1'b0) begin miscompares++;
            $display("FAIL prio_flag_edge: got cmdValid %b expected 0", cmdValid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if ({cmdValid, cmd} !== 4'b1100) begin miscompares++;
                $display("FAIL prio_down_hold[%0d]: got valid/cmd %b expected 1100", i, {cmdValid, cmd}); end
        end
        cmdReady = 1'b1;
        @(negedge clk);
        vectors++; if (cmdValid !== 1'b0) begin miscompares++;
            $display("FAIL prio_gap1: got cmdValid %b expected 0", cmdValid); end
        @(negedge clk);
        vectors++; if ({cmdValid, cmd} !== 4'b1011) begin miscompares++;
            $display("FAIL prio_rotate: got valid/cmd %b expected 1011", {cmdValid, cmd}); end
        @(negedge clk);
        vectors++; if (cmdValid !== 1'b0) begin miscompares++;
            $display("FAIL prio_gap2: got cmdValid %b expected 0", cmdValid); end
        @(negedge clk);
        vectors++; if ({cmdValid, cmd} !== 4'b1001) begin miscompares++;
            $display("FAIL prio_left: got valid/cmd %b expected 1001", {cmdValid, cmd}); end
        repeat (4) @(negedge clk);
        vectors++; if (acc_word !== 'o431) begin miscompares++;
            $display("FAIL prio_sequence: got %o expected 431", acc_word); end
        vectors++; if (tpulses !== 0) begin miscompares++;
            $display("FAIL prio_no_rstTimer: got %0d pulses expected 0", tpulses); end
    endtask

    task automatic test_soft_down();
        clear_logs();
        @(negedge clk); cmdReady = 1'b1; cmdBlocked = 1'b0; btnDown = 1'b1;
        @(negedge clk); btnDown = 1'b0;
        @(negedge clk);
        vectors++; if ({cmdValid, cmd, rstTimer} !== 5'b11000) begin miscompares++;
            $display("FAIL soft_issue: got valid/cmd/rstTimer %b expected 11000", {cmdValid, cmd, rstTimer}); end
        @(negedge clk);
        vectors++; if ({cmdValid, rstTimer} !== 2'b01) begin miscompares++;
            $display("FAIL soft_rstTimer: got valid/rstTimer %b expected 01", {cmdValid, rstTimer}); end
        @(negedge clk);
        vectors++; if (rstTimer !== 1'b0) begin miscompares++;
            $display("FAIL soft_rstTimer_width: got %b expected 0", rstTimer); end
        btnDown = 1'b1; cmdBlocked = 1'b1;
        @(negedge clk); btnDown = 1'b0;
        @(negedge clk);
        vectors++; if ({cmdValid, cmd} !== 4'b1100) begin miscompares++;
            $display("FAIL softblk_issue: got valid/cmd %b expected 1100", {cmdValid, cmd}); end
        @(negedge clk);
        vectors++; if ({cmdValid, cmd, rstTimer} !== 5'b11011) begin miscompares++;
            $display("FAIL softblk_lock: got valid/cmd/rstTimer %b expected 11011", {cmdValid, cmd, rstTimer}); end
        @(negedge clk);
        vectors++; if ({cmdValid, rstTimer} !== 2'b01) begin miscompares++;
            $display("FAIL softblk_lock_accept: got valid/rstTimer %b expected 01", {cmdValid, rstTimer}); end
        cmdBlocked = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (acc_word !== 'o445) begin miscompares++;
            $display("FAIL soft_sequence: got %o expected 445", acc_word); end
        vectors++; if (tpulses !== 3) begin miscompares++;
            $display("FAIL soft_pulse_count: got %0d expected 3", tpulses); end
    endtask

    task automatic test_hard_drop();
        clear_logs();
        @(negedge clk); cmdReady = 1'b1; cmdBlocked = 1'b0; btnDrop = 1'b1;
        @(negedge clk); btnDrop = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++; if ({cmdValid, cmd} !== 4'b1100) begin miscompares++;
                $display("FAIL drop_down[%0d]: got valid/cmd %b expected 1100", i, {cmdValid, cmd}); end
            cmdBlocked = (i == 3);
            btnLeft    = (i == 0);
            @(negedge clk);
        end
        cmdBlocked = 1'b0; btnLeft = 1'b0;
        vectors++; if ({cmdValid, cmd} !== 4'b1101) begin miscompares++;
            $display("FAIL drop_lock: got valid/cmd %b expected 1101", {cmdValid, cmd}); end
        repeat (6) @(negedge clk);
        vectors++; if (cmdValid !== 1'b0) begin miscompares++;
            $display("FAIL drop_no_left: got cmdValid %b cmd %0d expected idle", cmdValid, cmd); end
        vectors++; if (acc_word !== 'o44445) begin miscompares++;
            $display("FAIL drop_sequence: got %o expected 44445", acc_word); end
        vectors++; if (tpulses !== 5) begin miscompares++;
            $display("FAIL drop_pulse_count: got %0d expected 5", tpulses); end
    endtask

    task automatic test_set_clear();
        clear_logs();
        @(negedge clk); cmdReady = 1'b0; btnRight = 1'b1;
        @(negedge clk); btnRight = 1'b0;
        @(negedge clk);
        vectors++; if ({cmdValid, cmd} !== 4'b1010) begin miscompares++;
            $display("FAIL setclr_first: got valid/cmd %b expected 1010", {cmdValid, cmd}); end
        cmdReady = 1'b1; btnRight = 1'b1;
        @(negedge clk); btnRight = 1'b0;
        @(negedge clk);
        vectors++; if ({cmdValid, cmd} !== 4'b1010) begin miscompares++;
            $display("FAIL setclr_second: got valid/cmd %b expected 1010", {cmdValid, cmd}); end
        repeat (4) @(negedge clk);
        vectors++; if (acc_word !== 'o22) begin miscompares++;
            $display("FAIL setclr_sequence: got %o expected 22", acc_word); end
    endtask

    task automatic test_level();
        repeat (4) strobe_lines(3'd3);
        vectors++; if (level !== 4'd0) begin miscompares++;
            $display("FAIL level_latency: got %0d expected 0", level); end
        @(negedge clk);
        vectors++; if ({level, timeVal} !== {4'd1, 32'd25_000_000}) begin miscompares++;
            $display("FAIL level_one: got level %0d timeVal %0d expected 1 25000000", level, timeVal); end
        @(negedge clk);
        vectors++; if (timeVal !== 32'd23_000_000) begin miscompares++;
            $display("FAIL timeVal_one: got %0d expected 23000000", timeVal); end
        repeat (3) strobe_lines(3'd4);
        repeat (2) @(negedge clk);
        vectors++; if ({level, timeVal} !== {4'd2, 32'd21_000_000}) begin miscompares++;
            $display("FAIL level_two: got level %0d timeVal %0d expected 2 21000000", level, timeVal); end
        repeat (60) strobe_lines(3'd4);
        linesCleared = 3'd0;
        repeat (2) @(negedge clk);
        vectors++; if ({level, timeVal} !== {4'd15, 32'd5_000_000}) begin miscompares++;
            $display("FAIL level_saturate: got level %0d timeVal %0d expected 15 5000000", level, timeVal); end
    endtask

    task automatic test_reset_mid();
        int seen;
        clear_logs();
        @(negedge clk); cmdReady = 1'b0; btnLeft = 1'b1;
        @(negedge clk); btnLeft = 1'b0;
        for (int i = 0; i < 10 && !cmdValid; i++) @(negedge clk);
        vectors++; if ({cmdValid, cmd} !== 4'b1001) begin miscompares++;
            $display("FAIL rstmid_issue: got valid/cmd %b expected 1001", {cmdValid, cmd}); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({cmdValid, cmd} !== 4'b0000) begin miscompares++;
            $display("FAIL rstmid_cmd: got valid/cmd %b expected 0000", {cmdValid, cmd}); end
        vectors++; if ({level, timeVal} !== {4'd0, 32'd25_000_000}) begin miscompares++;
            $display("FAIL rstmid_level: got level %0d timeVal %0d expected 0 25000000", level, timeVal); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; cmdReady = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cmdValid) seen++;
        end
        vectors++; if (seen !== 0 || acc_word !== 0) begin miscompares++;
            $display("FAIL rstmid_no_stale: got %0d valid cycles, log %o expected 0 and 0", seen, acc_word); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_soft_down();
        test_hard_drop();
        test_set_clear();
        test_level();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
